// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller_if
// Description : Controller <-> multicycle datapath signal bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [3:0]  ALUControl;
  logic        storedCarry;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, storedCarry
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, storedCarry
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multicycle ARM sequencing FSM with NZCV flags and condition unit.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller (
  input  logic                           clk,
  input  logic                           reset,
  multicycle_controller_if.master        bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  nzcv_q, nzcv_d;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  cmd;
  logic        rd_is_pc;
  logic        cond_ex;
  logic        cmd_writes_cv;
  logic        unused_instr_bits;

  logic        pc_uncond, pc_gated, reg_gated, mem_gated, ir_en;
  logic        adr_src, alu_src_a;
  logic [1:0]  result_src, alu_src_b;
  logic [3:0]  alu_ctl;

  assign cond              = bus.Instr[31:28];
  assign op                = bus.Instr[27:26];
  assign funct             = bus.Instr[25:20];
  assign cmd               = funct[4:1];
  assign rd_is_pc          = (bus.Instr[15:12] == 4'hF);
  assign unused_instr_bits = ^{bus.Instr[19:16], bus.Instr[11:0]};

  // SUB/RSB/ADD/ADC/SBC/RSC and CMP/CMN update carry and overflow too
  assign cmd_writes_cv = ((cmd >= 4'd2) && (cmd <= 4'd7)) || (cmd[3:1] == 3'b101);

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = nzcv_q[2];
      4'b0001: cond_ex = ~nzcv_q[2];
      4'b0010: cond_ex = nzcv_q[1];
      4'b0011: cond_ex = ~nzcv_q[1];
      4'b0100: cond_ex = nzcv_q[3];
      4'b0101: cond_ex = ~nzcv_q[3];
      4'b0110: cond_ex = nzcv_q[0];
      4'b0111: cond_ex = ~nzcv_q[0];
      4'b1000: cond_ex = nzcv_q[1] & ~nzcv_q[2];
      4'b1001: cond_ex = ~nzcv_q[1] | nzcv_q[2];
      4'b1010: cond_ex = (nzcv_q[3] == nzcv_q[0]);
      4'b1011: cond_ex = (nzcv_q[3] != nzcv_q[0]);
      4'b1100: cond_ex = ~nzcv_q[2] & (nzcv_q[3] == nzcv_q[0]);
      4'b1101: cond_ex = nzcv_q[2] | (nzcv_q[3] != nzcv_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      nzcv_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      nzcv_q  <= nzcv_d;
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    nzcv_d     = nzcv_q;
    pc_uncond  = 1'b0;
    pc_gated   = 1'b0;
    reg_gated  = 1'b0;
    mem_gated  = 1'b0;
    ir_en      = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_ctl    = 4'b0100;
    case (state_q)
      S_FETCH: begin
        ir_en      = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_uncond  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_b = 2'b01;
        state_d   = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_gated  = 1'b1;
        pc_gated   = rd_is_pc;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_gated = 1'b1;
      end
      S_EXECUTER, S_EXECUTEI: begin
        alu_src_b = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
        alu_ctl   = cmd;
        state_d   = S_ALUWB;
        if (funct[0] && cond_ex) begin
          nzcv_d[3:2] = bus.ALUFlags[3:2];
          if (cmd_writes_cv) nzcv_d[1:0] = bus.ALUFlags[1:0];
        end
      end
      S_ALUWB: begin
        // TST/TEQ/CMP/CMN produce flags only, so neither Rd nor PC is written
        reg_gated = (cmd[3:2] != 2'b10);
        pc_gated  = (cmd[3:2] != 2'b10) && rd_is_pc;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_gated   = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are forced low in any cycle where reset is sampled asserted
  assign bus.PCWrite     = reset & (pc_uncond | (pc_gated & cond_ex));
  assign bus.RegWrite    = reset & reg_gated & cond_ex;
  assign bus.MemWrite    = reset & mem_gated & cond_ex;
  assign bus.IRWrite     = reset & ir_en;
  assign bus.AdrSrc      = adr_src;
  assign bus.ResultSrc   = result_src;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ImmSrc      = op;
  assign bus.RegSrc      = {(op == 2'b01), (op == 2'b10)};
  assign bus.ALUControl  = alu_ctl;
  assign bus.storedCarry = nzcv_q[1];

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Randomized self-checking bench against an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] m_nzcv   = 4'b0000;

  logic [18:0] obs;
  assign obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegSrc,
                bus.ALUControl, bus.storedCarry};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cy;         4'h3: return !cy;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cy && !z;   4'h9: return !cy || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int n_cycles(input logic [31:0] ins);
    case (ins[27:26])
      2'b01:   return ins[20] ? 5 : 4;
      2'b00:   return 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  // Expected controls for cycle k of instruction ins given architectural flags f
  function automatic logic [18:0] expect_vec(input logic [31:0] ins, input int k, input logic [3:0] f);
    logic [1:0] op;
    logic [3:0] cmd;
    bit ce, rd15, is_test;
    logic pcw, adr, mw, irw, rw, asa;
    logic [1:0] rs, asb;
    logic [3:0] ac;
    op = ins[27:26]; cmd = ins[24:21];
    ce = cond_holds(ins[31:28], f);
    rd15 = (ins[15:12] == 4'hF);
    is_test = (cmd[3:2] == 2'b10);
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; asa = 0; rs = 0; asb = 0; ac = 4'b0100;
    if (k == 0) begin
      pcw = 1; irw = 1; asa = 1; asb = 2'b10; rs = 2'b10;
    end else if (k == 1) begin
      asa = 1; asb = 2'b10; rs = 2'b10;
    end else if (op == 2'b01) begin
      if (k == 2) asb = 2'b01;
      else if (k == 3) begin adr = 1; if (!ins[20]) mw = ce; end
      else begin rs = 2'b01; rw = ce; pcw = ce && rd15; end
    end else if (op == 2'b00) begin
      if (k == 2) begin asb = ins[25] ? 2'b01 : 2'b00; ac = cmd; end
      else begin rw = ce && !is_test; pcw = ce && !is_test && rd15; end
    end else begin
      asb = 2'b01; rs = 2'b10; pcw = ce;
    end
    return {pcw, adr, mw, irw, rw, rs, asa, asb, op, (op == 2'b01), (op == 2'b10), ac, f[1]};
  endfunction

  // Starts at posedge+1 with the controller in FETCH; runs up to stop_k cycles
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] fl, input bit rnd,
                           input int stop_k, input string tag);
    int lat;
    logic [3:0] a;
    logic [3:0] cmd;
    lat = n_cycles(ins);
    cmd = ins[24:21];
    bus.Instr = ins;
    for (int k = 0; k < lat && k < stop_k; k++) begin
      a = rnd ? 4'($urandom) : fl;
      bus.ALUFlags = a;
      @(negedge clk);
      check_eq($sformatf("%s k%0d", tag, k), {13'd0, obs}, {13'd0, expect_vec(ins, k, m_nzcv)});
      if (ins[27:26] == 2'b00 && k == 2 && ins[20] && cond_holds(ins[31:28], m_nzcv)) begin
        if ((cmd >= 4'd2 && cmd <= 4'd7) || cmd == 4'hA || cmd == 4'hB) m_nzcv = a;
        else m_nzcv[3:2] = a[3:2];
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    bus.Instr = 32'h0;
    bus.ALUFlags = 4'h0;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_en", {28'd0, bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite}, 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    m_nzcv = 4'b0000;

    run_instr(32'hE5912004, 4'h0,    1'b0, 99, "ldr");
    run_instr(32'hE0521003, 4'b0110, 1'b0, 99, "subs");
    run_instr(32'hE0521003, 4'b0010, 1'b0, 99, "subs_nz");
    run_instr(32'h00810002, 4'b0100, 1'b0, 99, "addeq");
    run_instr(32'hE3500000, 4'b0110, 1'b0, 99, "cmp");
    run_instr(32'hEA000001, 4'h0,    1'b0, 99, "b");
    run_instr(32'hE0110002, 4'b1001, 1'b0, 99, "ands");
    run_instr(32'hE5812004, 4'h0,    1'b0, 99, "str");
    run_instr(32'hFC000000, 4'h0,    1'b0, 99, "undef");

    for (int i = 0; i < 300; i++)
      run_instr($urandom, 4'h0, 1'b1, 99, $sformatf("rnd%0d", i));

    // Reset in the middle of a load, while in MEMREAD
    run_instr(32'hE0521003, 4'b1111, 1'b0, 99, "subs_f");
    run_instr(32'hE5912004, 4'h0, 1'b0, 3, "ldr_part");
    reset = 1'b0;
    bus.ALUFlags = 4'h0;
    @(negedge clk);
    check_eq("midrst_en", {28'd0, bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_nzcv = 4'b0000;
    run_instr(32'hEA000001, 4'h0, 1'b0, 99, "post_rst");
    run_instr(32'h20810002, 4'h0, 1'b0, 99, "addcs_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
